// File: rtl/m68k_bus_master_if.sv
// m68k_bus_master_if: request port plus 68000-style bus signals for m68k_bus_master.
// The master modport is the initiator's view; slave is the requester/responder side.
interface m68k_bus_master_if;
   logic        req, req_rw, req_size;
   logic [23:0] req_addr;
   logic [2:0]  req_fc;
   logic [15:0] req_wdata;
   logic        busy, ack, err;
   logic [15:0] rdata;
   logic [23:0] a;
   logic [2:0]  fc;
   logic        siz0, siz1, rw, as_n, ds_n, uds_n, lds_n;
   logic [15:0] d_out, d_in;
   logic        d_oe, dtack_n, berr_n;
   modport master (
      input  req, req_rw, req_size, req_addr, req_fc, req_wdata, d_in, dtack_n, berr_n,
      output busy, ack, err, rdata, a, fc, siz0, siz1, rw, as_n, ds_n, uds_n, lds_n, d_out, d_oe
   );
   modport slave (
      output req, req_rw, req_size, req_addr, req_fc, req_wdata, d_in, dtack_n, berr_n,
      input  busy, ack, err, rdata, a, fc, siz0, siz1, rw, as_n, ds_n, uds_n, lds_n, d_out, d_oe
   );
endinterface

// File: rtl/m68k_bus_master.sv
// m68k_bus_master: single-transfer 68000-style bus initiator (read/write, byte/word).
// Define BUS_TIMEOUT_EN to force termination after TIMEOUT cycles in S_WAIT/S_TERM.
module m68k_bus_master
`ifdef BUS_TIMEOUT_EN
   #(parameter int TIMEOUT = 128)
`endif
   (
   input  logic              i_clk,
   input  logic              i_hwrst,
   m68k_bus_master_if.master io_bus
);
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_AS, S_WAIT, S_LATCH, S_TERM} state_t;
   state_t      r_state, w_next;
   logic [23:0] r_addr;
   logic [2:0]  r_fc;
   logic [1:0]  r_siz, r_dtack_s, r_berr_s;
   logic [15:0] r_dout, r_rdata, w_rd_lane;
   logic        r_rw, r_doe, r_ack, r_err, r_busy, r_fail;
   logic        w_dtack, w_berr, w_misaligned, w_reject, w_accept, w_done, w_tmo;
   logic        w_as, w_ds, w_uds_n, w_lds_n;
   assign w_dtack      = !r_dtack_s[1];
   assign w_berr       = !r_berr_s[1];
   assign w_misaligned = io_bus.req_size & io_bus.req_addr[0];
   assign w_reject     = (r_state == S_IDLE) & io_bus.req & w_misaligned;
   assign w_accept     = (r_state == S_IDLE) & io_bus.req & !w_misaligned;
   assign w_done       = (r_state == S_TERM) & (w_next == S_IDLE);
   // Byte lanes: A0 = 0 is the upper lane (UDS), A0 = 1 the lower lane (LDS)
   assign w_rd_lane = r_siz[1] ? io_bus.d_in
                               : {8'h00, r_addr[0] ? io_bus.d_in[7:0] : io_bus.d_in[15:8]};
`ifdef BUS_TIMEOUT_EN
   logic [15:0] r_tmo;
   always_ff @(posedge i_clk or posedge i_hwrst)
      if (i_hwrst) r_tmo <= 16'd0;
      else r_tmo <= (w_next != r_state) ? 16'd0
                  : (r_state == S_WAIT || r_state == S_TERM) ? r_tmo + 16'd1 : r_tmo;
   assign w_tmo = (r_state == S_WAIT || r_state == S_TERM) && r_tmo == 16'(TIMEOUT - 1);
`else
   assign w_tmo = 1'b0;
`endif
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = w_accept ? S_ADDR : S_IDLE;
         S_ADDR:  w_next = S_AS;
         S_AS:    w_next = S_WAIT;
         S_WAIT:  w_next = (w_berr | w_tmo) ? S_TERM : w_dtack ? S_LATCH : S_WAIT;
         S_LATCH: w_next = S_TERM;
         S_TERM:  w_next = ((!w_dtack & !w_berr) | w_tmo) ? S_IDLE : S_TERM;
         default: w_next = S_IDLE;
      endcase
      w_as = r_state inside {S_AS, S_WAIT, S_LATCH};
      // Write data strobes lag ASn by one cycle; read strobes assert with it
      w_ds = w_as & ((r_state != S_AS) | r_rw);
   end
   assign w_uds_n = !(w_ds & (r_siz[1] | !r_addr[0]));
   assign w_lds_n = !(w_ds & (r_siz[1] | r_addr[0]));
   always_ff @(posedge i_clk or posedge i_hwrst)
      if (i_hwrst) begin
         r_state   <= S_IDLE;
         r_addr    <= 24'd0;
         r_fc      <= 3'd0;
         r_siz     <= 2'b00;
         r_rw      <= 1'b1;
         r_dout    <= 16'd0;
         r_doe     <= 1'b0;
         r_rdata   <= 16'd0;
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
         r_fail    <= 1'b0;
         r_dtack_s <= 2'b11;
         r_berr_s  <= 2'b11;
      end else begin
         r_state   <= w_next;
         r_dtack_s <= {r_dtack_s[0], io_bus.dtack_n};
         r_berr_s  <= {r_berr_s[0], io_bus.berr_n};
         r_busy    <= (r_state != S_IDLE) | w_accept;
         r_ack     <= w_done & !r_fail & !w_tmo;
         r_err     <= w_reject | (w_done & (r_fail | w_tmo));
         if (w_accept) begin
            r_addr <= io_bus.req_addr;
            r_fc   <= io_bus.req_fc;
            r_siz  <= {io_bus.req_size, !io_bus.req_size};
            r_rw   <= io_bus.req_rw;
            r_dout <= io_bus.req_size ? io_bus.req_wdata : {2{io_bus.req_wdata[7:0]}};
            r_doe  <= !io_bus.req_rw;
            r_fail <= 1'b0;
         end
         if (r_state == S_WAIT && w_next == S_TERM) r_fail <= 1'b1;
         if (r_state == S_LATCH && r_rw) r_rdata <= w_rd_lane;
         if (w_done) begin
            r_doe <= 1'b0;
            r_rw  <= 1'b1;
         end
      end
   assign io_bus.busy  = r_busy;
   assign io_bus.ack   = r_ack;
   assign io_bus.err   = r_err;
   assign io_bus.rdata = r_rdata;
   assign io_bus.a     = r_addr;
   assign io_bus.fc    = r_fc;
   assign io_bus.siz1  = r_siz[1];
   assign io_bus.siz0  = r_siz[0];
   assign io_bus.rw    = r_rw;
   assign io_bus.as_n  = !w_as;
   assign io_bus.uds_n = w_uds_n;
   assign io_bus.lds_n = w_lds_n;
   assign io_bus.ds_n  = w_uds_n & w_lds_n;
   assign io_bus.d_out = r_dout;
   assign io_bus.d_oe  = r_doe;
endmodule

// File: doc/m68k_bus_master.md
# m68k_bus_master

Synchronous initiator for the 68000-style asynchronous bus that the glue logic decodes and terminates. It accepts single read or write requests on a simple request/acknowledge port and drives a full bus cycle: address, FC, SIZ, RW, ASn, DSn, UDSn and LDSn. It then waits for DTACKn or BERRn, captures read data and negates the strobes. It sits beside the CPU as a test and DMA master, and is used to exercise the address decoder, DTACK generator and watchdog from the master side.

## Interface
- TIMEOUT, 128: S_WAIT/S_TERM cycles before forced error (used only with BUS_TIMEOUT_EN).
- CLK  in  1  system clock; all state changes on rising edge.
- HWRST  in  1  asynchronous, active-high reset.
- REQ  in  1  request strobe; sampled only in S_IDLE.
- REQ_RW  in  1  1 = read, 0 = write.
- REQ_ADDR  in  24  byte address.
- REQ_SIZE  in  1  0 = byte, 1 = word.
- REQ_FC  in  3  function code to drive.
- REQ_WDATA  in  16  write data.
- BUSY  out  1  high from acceptance until the cycle after ACK/ERR.
- ACK  out  1  one-cycle pulse: cycle completed by DTACKn.
- ERR  out  1  one-cycle pulse: BERRn, misaligned word, or timeout.
- RDATA  out  16  read data; held until the next completed read.
- A  out  24  bus address.
- FC  out  3  function code.
- SIZ0, SIZ1  out  1 each  transfer size: byte = 01 (SIZ1 = 0, SIZ0 = 1), word = 10.
- RW  out  1  1 = read.
- ASn, DSn, UDSn, LDSn  out  1 each  active-low strobes.
- D_OUT  out  16  write data; D_OE  out  1  data bus drive enable.
- D_IN  in  16  read data from bus.
- DTACKn, BERRn  in  1 each  asynchronous terminations; each passes through a two-flop synchronizer before use.

## Operation
- States: S_IDLE, S_ADDR, S_AS, S_WAIT, S_LATCH, S_TERM.
- **S_IDLE**
  - REQ = 1 with REQ_SIZE = 1 and REQ_ADDR[0] = 1: ERR pulses and the block stays in S_IDLE. No bus activity occurs.
  - Otherwise REQ = 1 captures all REQ_* fields, sets BUSY and moves to S_ADDR.
- **S_ADDR** (1 cycle): drive A, FC, SIZ and RW. For writes, drive D_OUT with D_OE = 1. Strobes stay negated.
- **S_AS** (1 cycle): ASn = 0. For reads, DSn, UDSn and LDSn are also 0.
- **S_WAIT**
  - ASn = 0 and data strobes = 0. For writes, the data strobes assert here, one cycle after ASn.
  - BERR low: record an error and go to S_TERM. BERR has priority when it is low together with DTACK.
  - DTACK low: go to S_LATCH.
- **S_LATCH** (1 cycle): for reads, RDATA <= D_IN. Then go to S_TERM.
- **S_TERM**
  - All strobes are negated. D_OE is held through this state for write hold time.
  - Wait until DTACK and BERR are both high, then return to S_IDLE.
  - On that transition, pulse ACK or ERR and clear D_OE.
- **Lane rules**
  - Word: UDSn = LDSn = 0.
  - Byte with A0 = 0: UDSn only.
  - Byte with A0 = 1: LDSn only.
  - DSn = UDSn AND LDSn.
  - Byte writes replicate REQ_WDATA[7:0] onto both D_OUT bytes.
  - Byte reads return the selected lane in RDATA[7:0] and zero-fill RDATA[15:8].
- REQ while BUSY is ignored. REQ in the ACK/ERR cycle (S_IDLE) is accepted normally.

## Timing
- **Reset values:** ASn = DSn = UDSn = LDSn = 1, RW = 1, A = 0, FC = 0, SIZ0 = SIZ1 = 0, D_OUT = 0, D_OE = 0, RDATA = 0, ACK = ERR = BUSY = 0, state S_IDLE.
- HWRST asserted mid-cycle negates all strobes and D_OE immediately, without waiting for a clock.
- **Zero-wait responder** (DTACKn falls combinationally with ASn), REQ sampled at edge N:
  - ASn falls after edge N+1.
  - S_LATCH is entered at edge N+4.
  - ASn rises after edge N+5.
  - ACK is high in the cycle after edge N+8; BUSY falls at edge N+9.
- Each cycle of responder DTACK delay adds one cycle.
- The synchronizer adds two cycles of latency on both the assertion and the release of DTACKn/BERRn.

## Configuration
- **BUS_TIMEOUT_EN defined:** a 16-bit counter clears on entering S_WAIT and S_TERM and increments each cycle in those states.
  - Reaching TIMEOUT in S_WAIT forces S_TERM with an error.
  - Reaching TIMEOUT in S_TERM forces S_IDLE with an ERR pulse.
- **BUS_TIMEOUT_EN undefined:** no counter exists. The block waits indefinitely; termination relies on the external watchdog's BERRn.

## Test plan
- Word read at 0x000100, responder returns 0xBEEF with zero-wait DTACK -> ASn low for exactly 4 cycles, UDSn = LDSn = 0, SIZ = 10, ACK at N+8, RDATA = 0xBEEF.
- Byte write 0x5A at 0x000003 -> LDSn only, DSn asserted one cycle after ASn, D_OUT = 0x5A5A, D_OE high through S_TERM, ACK pulse.
- Word read at odd address 0x000101 -> ERR pulse the cycle after REQ, ASn never asserts, BUSY stays 0.
- Responder asserts BERRn (with DTACKn held high) 3 cycles after ASn -> strobes negate, ERR pulse, RDATA unchanged.
- With BUS_TIMEOUT_EN and TIMEOUT = 16, no termination -> ASn negates after 16 S_WAIT cycles, then ERR.
- HWRST pulsed while in S_WAIT -> ASn, DSn and D_OE go high asynchronously; after release, the next request completes normally.
